rgb555_to_ir_seq: RTL and testbench
===================================

RGB555_TO_IR_SEQ -- requirements
Module: rgb555_to_ir_seq

Interface
REQ-001 SHALL have parameter SWAP_RB, default 0, meaning 1 = emit channel order B,G,R instead of R,G,B.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_nRst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port i_clear  input  1  synchronous abort; discards the held pixel.
REQ-005 SHALL have port i_valid  input  1  input pixel valid.
REQ-006 SHALL have port o_ready  output  1  block accepts a pixel this cycle.
REQ-007 SHALL have port i_pix  input  16  packed pixel {mask, B[4:0], G[4:0], R[4:0]}.
REQ-008 SHALL have port o_valid  output  1  output component valid.
REQ-009 SHALL have port i_ready  input  1  consumer accepts the component.
REQ-010 SHALL have port o_sel  output  2  component index: 0=IR1, 1=IR2, 2=IR3; 3 never driven.
REQ-011 SHALL have port o_data  output  16  expanded signed component.
REQ-012 SHALL have port o_mask  output  1  mask bit of the held pixel.
REQ-013 SHALL have port o_last  output  1  high on the third component of a pixel.

Function
REQ-014 SHALL expand each 5-bit component c to {1'b0, 3'b000, c[4:0], 7'b0000000}, i.e. c*128, range 0..3968, never negative.
REQ-015 SHALL guarantee that a signed-16 to clamped-5 reduction (divide by 128, clamp to 0..31) of o_data returns c exactly.
REQ-016 SHALL implement states IDLE, EMIT0, EMIT1, EMIT2.
REQ-017 SHALL drive o_ready=1 in IDLE, and in EMIT2 when i_ready=1 and i_clear=0; otherwise 0.
REQ-018 SHALL capture i_pix when i_valid and o_ready are both high, and go to EMIT0.
REQ-019 SHALL drive o_valid=1 in EMIT0..EMIT2 and 0 in IDLE.
REQ-020 SHALL set o_sel to 0, 1, 2 in EMIT0, EMIT1, EMIT2 respectively.
REQ-021 SHALL source o_data from R, G, B for o_sel 0, 1, 2 when SWAP_RB=0, and from B, G, R when SWAP_RB=1.
REQ-022 SHALL advance EMITn to EMITn+1 only when i_ready=1, and hold state, o_sel and o_data while i_ready=0.
REQ-023 SHALL, in EMIT2 with i_ready=1, go to EMIT0 with the new pixel if i_valid=1, else go to IDLE.
REQ-024 SHALL support back-to-back pixels at 3 cycles per pixel with zero bubble.
REQ-025 SHALL have latency of one cycle from accept to the first o_valid.
REQ-026 SHALL drive o_last=1 only in EMIT2, and o_mask from the held pixel's bit 15.
REQ-027 SHALL, on i_clear=1, go to IDLE next cycle regardless of state, accept nothing that cycle, and drop any partially emitted pixel.
REQ-028 SHALL give i_clear priority over a simultaneous accept or advance.

Reset
REQ-029 SHALL on i_nRst=0 immediately force IDLE, o_valid=0, o_ready=0 while asserted, o_sel=0, o_data=0, o_mask=0, o_last=0, and held pixel=0.
REQ-030 SHALL abort any pixel in flight on reset mid-operation, with no component emitted after release until a new accept.
REQ-031 SHALL drive o_ready=1 from the first cycle after reset release.

Structure
REQ-032 SHALL place the state enum and the component-index constants (IR1=0, IR2=1, IR3=2) in the shared GTE package.
REQ-033 SHALL instantiate one combinational sub-module, m5to16, performing the 5-to-16 expansion of REQ-014.
REQ-034 SHALL register o_data, o_sel, o_mask and o_last; no combinational path from i_pix to outputs.

Verification
REQ-035 SHALL cover: pixel 0x7FFF with i_ready tied high -> o_data 0x0F80,0x0F80,0x0F80, o_sel 0,1,2, o_mask=0, o_last only on third.
REQ-036 SHALL cover: pixel 0x8421 (R=1,G=1,B=1,mask=1) then 0x001F back-to-back -> 0x0080 x3 then 0x0F80,0x0000,0x0000 across 6 consecutive cycles, o_ready high on cycles 3 and 6.
REQ-037 SHALL cover: i_ready low 4 cycles during EMIT1 -> o_sel=1 and o_data held stable, o_ready=0 throughout.
REQ-038 SHALL cover: i_clear in EMIT1 with i_valid high -> IDLE next cycle, no third component, next pixel accepted afterwards.
REQ-039 SHALL cover: async reset asserted mid EMIT2 -> outputs zero before the next clk edge, IDLE after release.
REQ-040 SHALL cover: SWAP_RB=1 with pixel 0x03E0|0x0001 -> o_data 0x0000,0x0F80,0x0080 in that order.

Source files
------------

// File: rtl/rgb555_to_ir_seq_pkg.sv
// Shared definitions for the RGB555 to IR component sequencer: FSM state
// encoding, component index constants and the channel selection helper.
package rgb555_to_ir_seq_pkg;

    // Sequencer states: IDLE waits for a pixel, EMITn presents component n.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT0 = 2'd1,
        EMIT1 = 2'd2,
        EMIT2 = 2'd3
    } stateT;

    // Component index values driven on o_sel.
    localparam logic [1:0] IR1 = 2'd0;
    localparam logic [1:0] IR2 = 2'd1;
    localparam logic [1:0] IR3 = 2'd2;

    localparam int PIX_W  = 16;
    localparam int COMP_W = 5;
    localparam int DATA_W = 16;

    // Pick the 5-bit channel for a component index. G is always in the
    // middle; swapRb exchanges which of R/B comes first.
    function automatic logic [COMP_W-1:0] pickComponent(
        input logic [PIX_W-1:0] pix,
        input logic [1:0]       sel,
        input logic             swapRb
    );
        logic [COMP_W-1:0] red;
        logic [COMP_W-1:0] green;
        logic [COMP_W-1:0] blue;
        red   = pix[4:0];
        green = pix[9:5];
        blue  = pix[14:10];
        case (sel)
            IR1:     pickComponent = swapRb ? blue : red;
            IR2:     pickComponent = green;
            IR3:     pickComponent = swapRb ? red : blue;
            default: pickComponent = '0;
        endcase
    endfunction

endpackage

// File: rtl/rgb555_to_ir_seq_m5to16.sv
// Expands a 5-bit unsigned colour component into a non-negative signed
// 16-bit value (c * 128). Dividing by 128 and clamping to 0..31 recovers c.
module m5to16 (
    input  logic [4:0]  i_comp,
    output logic [15:0] o_data
);

    // Sign bit and headroom are zero, component sits at bits [11:7].
    assign o_data = {1'b0, 3'b000, i_comp, 7'b0000000};

endmodule

// File: rtl/rgb555_to_ir_seq.sv
// Serialises one RGB555 pixel into three expanded components (IR1..IR3).
//
// Handshake: an input pixel transfers on a rising edge where i_valid and
// o_ready are both high and i_clear is low; an output component transfers
// on a rising edge where o_valid and i_ready are both high and i_clear is
// low. o_sel/o_data/o_mask/o_last are stable while o_valid && !i_ready.
module rgb555_to_ir_seq
    import rgb555_to_ir_seq_pkg::*;
#(
    parameter bit SWAP_RB = 1'b0
) (
    input  logic        clk,
    input  logic        i_nRst,
    input  logic        i_clear,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [15:0] i_pix,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [1:0]  o_sel,
    output logic [15:0] o_data,
    output logic        o_mask,
    output logic        o_last,
    output stateT       o_dbgState
);

    stateT             state;
    stateT             nextState;
    logic [PIX_W-1:0]  pixReg;
    logic [PIX_W-1:0]  nextPix;
    logic [1:0]        nextSel;
    logic [COMP_W-1:0] nextComp;
    logic [DATA_W-1:0] nextData;

    // State and held-pixel register.
    always_ff @(posedge clk or negedge i_nRst) begin
        if (!i_nRst) begin
            state  <= IDLE;
            pixReg <= '0;
        end else begin
            state  <= nextState;
            pixReg <= nextPix;
        end
    end

    // Next-state and held-pixel selection; clear overrides everything.
    always_comb begin
        nextState = state;
        nextPix   = pixReg;
        if (i_clear) begin
            nextState = IDLE;
            nextPix   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        nextState = EMIT0;
                        nextPix   = i_pix;
                    end
                end
                EMIT0: if (i_ready) nextState = EMIT1;
                EMIT1: if (i_ready) nextState = EMIT2;
                EMIT2: begin
                    if (i_ready) begin
                        if (i_valid) begin
                            nextState = EMIT0;
                            nextPix   = i_pix;
                        end else begin
                            nextState = IDLE;
                        end
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

    // Handshake outputs and the component index for the coming cycle.
    always_comb begin
        o_ready  = i_nRst && ((state == IDLE) ||
                              ((state == EMIT2) && i_ready && !i_clear));
        o_valid  = (state != IDLE);
        case (nextState)
            EMIT1:   nextSel = IR2;
            EMIT2:   nextSel = IR3;
            default: nextSel = IR1;
        endcase
        nextComp = pickComponent(nextPix, nextSel, SWAP_RB);
    end

    m5to16 u_m5to16 (
        .i_comp (nextComp),
        .o_data (nextData)
    );

    // Registered component outputs, aligned with the state register.
    always_ff @(posedge clk or negedge i_nRst) begin
        if (!i_nRst) begin
            o_sel  <= IR1;
            o_data <= '0;
            o_mask <= 1'b0;
            o_last <= 1'b0;
        end else begin
            o_sel  <= nextSel;
            o_data <= (nextState == IDLE) ? '0 : nextData;
            o_mask <= nextPix[15];
            o_last <= (nextState == EMIT2);
        end
    end

    assign o_dbgState = state;

endmodule

// File: tb/tb_rgb555_to_ir_seq.sv
// Bench for rgb555_to_ir_seq: two instances (R,G,B and B,G,R order) share
// the stimulus; a queue model predicts every component and the handshake.
module tb_rgb555_to_ir_seq;
    import rgb555_to_ir_seq_pkg::*;

    logic        clk = 1'b0;
    logic        i_nRst = 1'b1;
    logic        i_clear = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b1;
    logic [15:0] i_pix = '0;

    logic        aReady, aValid, aMask, aLast;
    logic [1:0]  aSel;
    logic [15:0] aData;
    stateT       aState;
    logic        bReady, bValid, bMask, bLast;
    logic [1:0]  bSel;
    logic [15:0] bData;
    stateT       bState;

    int errors = 0;
    int checks = 0;

    // {last, mask, sel, data}
    logic [19:0] expQA[$];
    logic [19:0] expQB[$];
    logic        expReady;

    logic [15:0] t2Data [6] = '{16'h0080, 16'h0080, 16'h0080, 16'h0F80, 16'h0000, 16'h0000};
    logic [1:0]  t2Sel  [6] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic        t2Mask [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        t2Ready[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] t5DataB[3] = '{16'h0000, 16'h0F80, 16'h0080};
    logic [15:0] t5DataA[3] = '{16'h0080, 16'h0F80, 16'h0000};

    always #5 clk = ~clk;

    rgb555_to_ir_seq #(.SWAP_RB(1'b0)) dutA (
        .clk(clk), .i_nRst(i_nRst), .i_clear(i_clear), .i_valid(i_valid),
        .o_ready(aReady), .i_pix(i_pix), .o_valid(aValid), .i_ready(i_ready),
        .o_sel(aSel), .o_data(aData), .o_mask(aMask), .o_last(aLast),
        .o_dbgState(aState)
    );

    rgb555_to_ir_seq #(.SWAP_RB(1'b1)) dutB (
        .clk(clk), .i_nRst(i_nRst), .i_clear(i_clear), .i_valid(i_valid),
        .o_ready(bReady), .i_pix(i_pix), .o_valid(bValid), .i_ready(i_ready),
        .o_sel(bSel), .o_data(bData), .o_mask(bMask), .o_last(bLast),
        .o_dbgState(bState)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Component idx of a pixel: channel 0=R,1=G,2=B, reversed R/B when swapped.
    function automatic logic [19:0] entryFor(input logic [15:0] pix, input int idx, input bit swapRb);
        int          src;
        logic [15:0] sh;
        logic [15:0] wide;
        src = idx;
        if (swapRb && idx != 1) src = 2 - idx;
        sh   = pix >> (5 * src);
        wide = 16'(sh[4:0]) * 16'd128;
        return {(idx == 2), pix[15], 2'(idx), wide};
    endfunction

    // Scoreboard: compare at the falling edge, then advance the model for the next rising edge.
    always @(negedge clk) begin
        if (!i_nRst) begin
            expQA.delete();
            expQB.delete();
            check("rst_outA", 32'({aValid, aReady, aSel, aData, aMask, aLast}), 32'd0);
            check("rst_outB", 32'({bValid, bReady, bSel, bData, bMask, bLast}), 32'd0);
        end else begin
            expReady = (expQA.size() == 0) || (expQA.size() == 1 && i_ready && !i_clear);
            check("readyA", 32'(aReady), 32'(expReady));
            check("readyB", 32'(bReady), 32'(expReady));
            check("validA", 32'(aValid), 32'(expQA.size() != 0));
            check("validB", 32'(bValid), 32'(expQB.size() != 0));
            if (aValid && expQA.size() != 0)
                check("compA", 32'({aLast, aMask, aSel, aData}), 32'(expQA[0]));
            if (bValid && expQB.size() != 0)
                check("compB", 32'({bLast, bMask, bSel, bData}), 32'(expQB[0]));
            if (i_clear) begin
                expQA.delete();
                expQB.delete();
            end else begin
                if (expQA.size() != 0 && i_ready) begin
                    void'(expQA.pop_front());
                    void'(expQB.pop_front());
                end
                if (i_valid && expReady) begin
                    for (int k = 0; k < 3; k++) begin
                        expQA.push_back(entryFor(i_pix, k, 1'b0));
                        expQB.push_back(entryFor(i_pix, k, 1'b1));
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sendPix(input logic [15:0] p);
        i_valid = 1'b1;
        i_pix   = p;
        step();
        i_valid = 1'b0;
    endtask

    initial begin
        #1 i_nRst = 1'b0;
        @(negedge clk);
        check("rst_stateA", 32'(aState), 32'(IDLE));
        @(negedge clk);
        step();
        i_nRst = 1'b1;
        @(negedge clk);
        check("rel_readyA", 32'(aReady), 32'd1);
        step();

        // Full-scale pixel, consumer always ready.
        i_ready = 1'b1;
        sendPix(16'h7FFF);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t1_data", 32'(aData), 32'h0F80);
            check("t1_sel", 32'(aSel), 32'(k));
            check("t1_last", 32'(aLast), 32'(k == 2));
            check("t1_mask", 32'(aMask), 32'd0);
            step();
        end

        // Two pixels back-to-back, no bubble.
        i_valid = 1'b1;
        i_pix   = 16'h8421;
        step();
        i_pix   = 16'h001F;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("t2_data", 32'(aData), 32'(t2Data[k]));
            check("t2_sel", 32'(aSel), 32'(t2Sel[k]));
            check("t2_mask", 32'(aMask), 32'(t2Mask[k]));
            check("t2_ready", 32'(aReady), 32'(t2Ready[k]));
            check("t2_valid", 32'(aValid), 32'd1);
            step();
            if (k == 2) i_valid = 1'b0;
        end

        // Consumer stalls in EMIT1 for four cycles.
        sendPix(16'h5555);
        step();
        i_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t3_sel", 32'(aSel), 32'd1);
            check("t3_data", 32'(aData), 32'h0500);
            check("t3_ready", 32'(aReady), 32'd0);
            step();
        end
        i_ready = 1'b1;
        step();
        @(negedge clk);
        check("t3_sel2", 32'(aSel), 32'd2);
        check("t3_data2", 32'(aData), 32'h0A80);
        step();

        // Clear in EMIT1 with a new pixel offered.
        sendPix(16'h1234);
        step();
        i_clear = 1'b1;
        i_valid = 1'b1;
        i_pix   = 16'h7C00;
        @(negedge clk);
        check("t4_readyClr", 32'(aReady), 32'd0);
        step();
        i_clear = 1'b0;
        @(negedge clk);
        check("t4_idle", 32'(aValid), 32'd0);
        check("t4_readyIdle", 32'(aReady), 32'd1);
        step();
        i_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_sel", 32'(aSel), 32'(k));
            check("t4_data", 32'(aData), (k == 2) ? 32'h0F80 : 32'h0);
            step();
        end

        // Swapped channel order on the second instance.
        sendPix(16'h03E1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_dataB", 32'(bData), 32'(t5DataB[k]));
            check("t5_dataA", 32'(aData), 32'(t5DataA[k]));
            step();
        end

        // Asynchronous reset while holding EMIT2.
        sendPix(16'hFFFF);
        step();
        step();
        i_ready = 1'b0;
        @(negedge clk);
        check("t6_inEmit2", 32'(aLast), 32'd1);
        #2 i_nRst = 1'b0;
        #1;
        check("t6_asyncA", 32'({aValid, aReady, aSel, aData, aMask, aLast}), 32'd0);
        check("t6_asyncB", 32'({bValid, bReady, bSel, bData, bMask, bLast}), 32'd0);
        @(negedge clk);
        step();
        i_nRst  = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("t6_noEmit", 32'(aValid), 32'd0);
            step();
        end

        // Randomised traffic, stalls, clears and occasional resets.
        for (int n = 0; n < 3000; n++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_clear = ($urandom_range(0, 31) == 0);
            i_pix   = 16'($urandom);
            i_nRst  = ($urandom_range(0, 255) != 0);
            step();
        end
        i_nRst  = 1'b1;
        i_valid = 1'b0;
        i_clear = 1'b0;
        i_ready = 1'b1;
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
